// File: rtl/suma_ctrl.sv
// Button-driven saturating accumulator controller: debounced press -> add -> BCD conversion handshake.
// Presses arriving while busy are held in a one-deep pending slot; extras are dropped.
module suma_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned MAX_VALUE       = 9999,
    parameter int unsigned CONV_TIMEOUT    = 64
) (
    input  logic        clk_pi,
    input  logic        rst_pi,
    input  logic [3:0]  dipswitch,
    input  logic        suma_btn,
    input  logic        bcd_done_pi,
    output logic [15:0] acc_po,
    output logic        bcd_start_po,
    output logic [15:0] bcd_bin_po,
    output logic        busy_po,
    output logic        ovf_po,
    output logic        conv_err_po
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(CONV_TIMEOUT + 1);
    localparam logic [16:0] MAX17 = 17'(MAX_VALUE);

    typedef enum logic [1:0] {IDLE, ADD, CONV_START, CONV_WAIT} state_t;

    logic            sync1_q, sync2_q, deb_q, press_q;
    logic [DB_W-1:0] db_cnt_q;

    state_t          state_q;
    logic [3:0]      op_q, pend_op_q;
    logic            pend_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [15:0]     acc_q, bin_q;
    logic            start_q, busy_q, ovf_q, err_q;
    logic [16:0]     sum_d, sat_d;

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_pi) begin
        if (!rst_pi) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            deb_q    <= 1'b0;
            press_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q <= suma_btn;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == deb_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_q <= '0;
                deb_q    <= sync2_q;
                press_q  <= sync2_q;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign sum_d = {1'b0, acc_q} + {13'd0, op_q};
    assign sat_d = (sum_d > MAX17) ? MAX17 : sum_d;

    always_ff @(posedge clk_pi) begin
        if (!rst_pi) begin
            state_q   <= IDLE;
            op_q      <= '0;
            pend_op_q <= '0;
            pend_q    <= 1'b0;
            to_cnt_q  <= '0;
            acc_q     <= '0;
            bin_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (press_q && state_q != IDLE && !pend_q) begin
                pend_q    <= 1'b1;
                pend_op_q <= dipswitch;
            end
            case (state_q)
                IDLE: begin
                    // A queued press wins; a fresh press in the same cycle is dropped.
                    if (pend_q) begin
                        op_q    <= pend_op_q;
                        pend_q  <= 1'b0;
                        state_q <= ADD;
                        busy_q  <= 1'b1;
                    end else if (press_q) begin
                        op_q    <= dipswitch;
                        state_q <= ADD;
                        busy_q  <= 1'b1;
                    end
                end
                ADD: begin
                    acc_q   <= sat_d[15:0];
                    bin_q   <= sat_d[15:0];
                    start_q <= 1'b1;
                    if (sum_d > MAX17) ovf_q <= 1'b1;
                    state_q <= CONV_START;
                end
                CONV_START: begin
                    to_cnt_q <= '0;
                    state_q  <= CONV_WAIT;
                end
                CONV_WAIT: begin
                    if (bcd_done_pi) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (to_cnt_q == TO_W'(CONV_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign acc_po       = acc_q;
    assign bcd_start_po = start_q;
    assign bcd_bin_po   = bin_q;
    assign busy_po      = busy_q;
    assign ovf_po       = ovf_q;
    assign conv_err_po  = err_q;
endmodule

// File: tb/tb_suma_ctrl.sv
// Bench for suma_ctrl with short debounce/timeout; scoreboard checks every conversion start.
module tb_suma_ctrl;
    localparam int DB   = 4;
    localparam int TO   = 16;
    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dip = 4'd0;
    logic        btn = 1'b0;
    logic        bcd_done = 1'b0;
    logic [15:0] acc_po, bcd_bin_po;
    logic        bcd_start_po, busy_po, ovf_po, conv_err_po;

    always #5 clk = ~clk;

    suma_ctrl #(.DEBOUNCE_CYCLES(DB), .MAX_VALUE(MAXV), .CONV_TIMEOUT(TO)) dut (
        .clk_pi(clk), .rst_pi(rst_n), .dipswitch(dip), .suma_btn(btn),
        .bcd_done_pi(bcd_done), .acc_po(acc_po), .bcd_start_po(bcd_start_po),
        .bcd_bin_po(bcd_bin_po), .busy_po(busy_po), .ovf_po(ovf_po),
        .conv_err_po(conv_err_po)
    );

    int total = 0, bad = 0;
    int cyc = 0, starts = 0, last_start = 0;
    int conv_dly = 5, conv_cnt = 0;
    int acc_m = 0;
    logic ovf_m = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    typedef struct { logic [3:0] dip; logic [15:0] acc; } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Converter model: done pulse conv_dly cycles after start; conv_dly of 0 means never answer.
    always @(posedge clk) begin
        #1;
        bcd_done = 1'b0;
        if (!rst_n) conv_cnt = 0;
        else begin
            if (conv_cnt > 0) begin
                conv_cnt--;
                if (conv_cnt == 0) bcd_done = 1'b1;
            end
            if (bcd_start_po && conv_dly > 0) conv_cnt = conv_dly;
        end
    end

    always @(negedge clk) begin
        if (bcd_start_po === 1'b1) begin
            starts++;
            last_start = cyc;
            chk("sb_nonempty", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("start_acc", acc_po, e);
                chk("start_bin", bcd_bin_po, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_add(input int d);
        if (acc_m + d > MAXV) begin
            acc_m = MAXV;
            ovf_m = 1'b1;
        end else acc_m += d;
        exp_q.push_back(16'(acc_m));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (busy_po === 1'b0) break;
            tick(1);
        end
        chk("idle_wait", busy_po, 0);
    endtask

    task automatic press(input logic [3:0] d);
        model_add(d);
        dip = d;
        btn = 1'b1;
        tick(10);
        btn = 1'b0;
        tick(8);
        wait_idle();
    endtask

    // Presses with period 8 cycles (4 high, 4 low), the fastest the debouncer accepts.
    task automatic burst(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input int n);
        logic [3:0] ds[3];
        ds[0] = d0; ds[1] = d1; ds[2] = d2;
        for (int i = 0; i < n; i++) begin
            dip = ds[i];
            btn = 1'b1;
            tick(4);
            btn = 1'b0;
            tick(4);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        acc_m = 0;
        ovf_m = 1'b0;
        exp_q.delete();
        tick(1);
    endtask

    initial begin
        int s0, raise_cyc;
        tbl[0] = '{4'd1, 16'd1};
        tbl[1] = '{4'd2, 16'd3};
        tbl[2] = '{4'd4, 16'd7};
        tbl[3] = '{4'd8, 16'd15};
        tbl[4] = '{4'd5, 16'd20};

        tick(3);
        chk("rst_acc", acc_po, 0);
        chk("rst_bin", bcd_bin_po, 0);
        chk("rst_start", bcd_start_po, 0);
        chk("rst_busy", busy_po, 0);
        chk("rst_ovf", ovf_po, 0);
        chk("rst_err", conv_err_po, 0);
        rst_n = 1'b1;
        tick(2);

        // Single clean press, raw edge to start latency.
        model_add(1);
        dip = 4'd1;
        btn = 1'b1;
        raise_cyc = cyc;
        tick(10);
        btn = 1'b0;
        tick(8);
        wait_idle();
        chk("t1_latency", last_start - raise_cyc, 8);
        chk("t1_acc", acc_po, 1);
        chk("t1_bin", bcd_bin_po, 1);
        chk("t1_starts", starts, 1);

        // Table sequence.
        do_reset();
        s0 = starts;
        for (int i = 0; i < 5; i++) begin
            press(tbl[i].dip);
            chk("t2_acc", acc_po, tbl[i].acc);
        end
        chk("t2_starts", starts - s0, 5);

        // Reset during CONV_WAIT with a pending press queued.
        conv_dly = 0;
        model_add(0);
        burst(4'd0, 4'd7, 4'd0, 2);
        chk("t6_pre_acc", acc_po, 20);
        chk("t6_pre_busy", busy_po, 1);
        rst_n = 1'b0;
        tick(1);
        chk("t6_acc", acc_po, 0);
        chk("t6_bin", bcd_bin_po, 0);
        chk("t6_start", bcd_start_po, 0);
        chk("t6_busy", busy_po, 0);
        chk("t6_ovf", ovf_po, 0);
        chk("t6_err", conv_err_po, 0);
        rst_n = 1'b1;
        acc_m = 0;
        exp_q.delete();
        conv_dly = 5;
        s0 = starts;
        tick(30);
        chk("t6_no_start", starts - s0, 0);
        chk("t6_acc_after", acc_po, 0);

        // Bouncing button yields a single press.
        s0 = starts;
        model_add(3);
        dip = 4'd3;
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1; tick(2);
            btn = 1'b0; tick(2);
        end
        btn = 1'b1; tick(10);
        btn = 1'b0; tick(8);
        wait_idle();
        chk("t3_starts", starts - s0, 1);
        chk("t3_acc", acc_po, 3);

        // Converter timeout.
        conv_dly = 0;
        model_add(1);
        dip = 4'd1;
        btn = 1'b1;
        tick(10);
        btn = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (conv_err_po === 1'b1) break;
            tick(1);
        end
        chk("t5_err", conv_err_po, 1);
        chk("t5_err_delay", cyc - last_start, TO + 1);
        chk("t5_busy", busy_po, 0);
        conv_dly = 5;
        tick(8);

        // Second press pends during CONV_WAIT, third is dropped.
        s0 = starts;
        conv_dly = 15;
        model_add(1);
        model_add(2);
        burst(4'd1, 4'd2, 4'd4, 3);
        conv_dly = 5;
        tick(20);
        wait_idle();
        chk("t5b_starts", starts - s0, 2);
        chk("t5b_acc", acc_po, 7);

        // Saturation.
        while (acc_m + 15 <= 9995) press(4'd15);
        press(4'(9995 - acc_m));
        chk("t4_preload", acc_po, 9995);
        chk("t4_ovf_pre", ovf_po, 0);
        press(4'd15);
        chk("t4_sat", acc_po, MAXV);
        chk("t4_ovf", ovf_po, ovf_m);
        s0 = starts;
        press(4'd1);
        chk("t4_sat2", acc_po, MAXV);
        chk("t4_ovf2", ovf_po, 1);
        chk("t4_conv_ran", starts - s0, 1);
        chk("t4_err_sticky", conv_err_po, 1);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/suma_ctrl.md
# suma_ctrl

Sequencing controller for the accumulator datapath behind `module_top`. It conditions the raw `suma_btn` push-button into single press events and captures the 4-bit dipswitch operand on each press. It performs a saturating add into the 16-bit accumulator, then hands the new value to the binary-to-BCD converter through a start/done handshake, with a timeout, before accepting the next add.

## Interface
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable cycles required to accept a button level change (10 ms at 27 MHz).
- `MAX_VALUE`, default 9999: accumulator saturation ceiling (4 display digits).
- `CONV_TIMEOUT`, default 64: cycles allowed in CONV_WAIT before aborting.
- `clk_pi`, in, 1: system clock, 27 MHz.
- `rst_pi`, in, 1: synchronous, active-low reset.
- `dipswitch`, in, 4: unsigned operand.
- `suma_btn`, in, 1: raw asynchronous push-button, active-high.
- `bcd_done_pi`, in, 1: converter completion pulse.
- `acc_po`, out, 16: accumulator value.
- `bcd_start_po`, out, 1: one-cycle converter start pulse.
- `bcd_bin_po`, out, 16: value to convert; held stable from start until the next start.
- `busy_po`, out, 1: high whenever state ≠ IDLE.
- `ovf_po`, out, 1: sticky saturation flag.
- `conv_err_po`, out, 1: sticky converter-timeout flag.

## Operation
- **Input path:** `suma_btn` passes through a 2-FF synchronizer, then a debouncer.
  - The debounce counter clears whenever the synchronized level equals the debounced level.
  - When they differ for `DEBOUNCE_CYCLES` consecutive cycles, the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse on a 0→1 debounced transition. Release generates nothing.
- **Operand capture:** `dipswitch` is sampled on the press-event cycle into an operand register.
- **Press handling:**
  - In IDLE, a press event is consumed directly.
  - In any other state it sets a one-deep `pending` flag, with its own operand register.
  - Further presses while `pending` is set are dropped.
- **FSM states:** IDLE, ADD, CONV_START, CONV_WAIT.
  - IDLE → ADD on a press event, or when `pending` is set (this clears `pending` and uses the pending operand).
  - ADD: computes sum = `acc` + operand in 17 bits.
    - If sum > `MAX_VALUE`: `acc` ← `MAX_VALUE` and `ovf_po` ← 1.
    - Otherwise: `acc` ← sum.
    - Always → CONV_START.
  - CONV_START: `bcd_start_po` = 1, `bcd_bin_po` ← new `acc`, timeout counter cleared → CONV_WAIT.
  - CONV_WAIT: on `bcd_done_pi` → IDLE. Otherwise the counter increments; on reaching `CONV_TIMEOUT` → IDLE with `conv_err_po` ← 1.
- **Rule precedence:**
  - `bcd_done_pi` in the same cycle as timeout expiry counts as done; `conv_err_po` is unchanged.
  - `bcd_done_pi` outside CONV_WAIT is ignored.
  - A press event in the same cycle the FSM returns to IDLE sets `pending` and is processed on the following cycle.
  - `ovf_po` and `conv_err_po` clear only on reset.
  - Once saturated, further adds keep `acc` at `MAX_VALUE` and still run a conversion.

## Timing
- **Reset:** while `rst_pi` is low at a clock edge, all of the following clear:
  - `acc_po` = 0, `bcd_bin_po` = 0, `bcd_start_po` = 0, `busy_po` = 0, `ovf_po` = 0, `conv_err_po` = 0.
  - Synchronizer flops, debounced level, debounce counter, timeout counter and `pending` = 0; state = IDLE.
- **Reset mid-operation:** an add or conversion in progress is abandoned. `bcd_start_po` is never asserted in the cycle after reset release.
- **Button held through reset release:** produces exactly one press event, after `DEBOUNCE_CYCLES` + 2 cycles.
- **Raw edge to press event:** 2 + `DEBOUNCE_CYCLES` cycles.
- **Press event to outputs:** press event at cycle N (state IDLE):
  - N+1: state ADD, `busy_po` high.
  - N+2: `acc_po` shows the new value, `bcd_start_po` high, `bcd_bin_po` valid.
  - `busy_po` falls the cycle after `bcd_done_pi` is sampled.
- **Back-to-back:** a pending add starts the cycle after return to IDLE; minimum spacing between two `bcd_start_po` pulses is 4 cycles.
- **Timeout:** `conv_err_po` rises `CONV_TIMEOUT` + 1 cycles after the `bcd_start_po` cycle.

## Test plan
Bench setup: `DEBOUNCE_CYCLES` = 4, `CONV_TIMEOUT` = 16; the converter model returns `bcd_done_pi` 5 cycles after start unless stated.

1. Reset, `dipswitch` = 1, clean press held 10 cycles → one `bcd_start_po`, `acc_po` = 1, `bcd_bin_po` = 1, `busy_po` low after done.
2. Sequence 1, 2, 4, 8, 5 → `acc_po` 1, 3, 7, 15, 20; exactly 5 start pulses.
3. Button bounces 0/1 every 2 cycles for 20 cycles, then stable high → exactly one press.
4. Preload to 9995 (repeated adds), `dipswitch` = 15, press → `acc_po` = 9999, `ovf_po` = 1; a further press keeps 9999 and `ovf_po` stays high.
5. Converter never answers → `conv_err_po` rises 17 cycles after start and state returns to IDLE. Separately, a second press during CONV_WAIT executes after done; a third press in the same window is dropped.
6. Assert `rst_pi` low during CONV_WAIT with `acc_po` = 20 → all outputs 0 next cycle; the pending press is discarded.
